// File: rtl/array_port_arbiter_if.sv
// rtl/array_port_arbiter_if.sv - single-word req/ack requester port into the array arbiter
interface array_port_arbiter_if #(
   parameter int datlen    = 12,
   parameter int size_log2 = 6
);
   logic                 req;
   logic                 wr;
   logic [size_log2-1:0] index;
   logic [datlen-1:0]    wdata;
   logic                 ack;
   logic                 err;
   logic [datlen-1:0]    rdata;

   modport master (output req, wr, index, wdata, input ack, err, rdata);
   modport slave  (input req, wr, index, wdata, output ack, err, rdata);
endinterface

// File: rtl/array_port_arbiter.sv
// rtl/array_port_arbiter.sv - two-requester arbiter for an edge-strobed array (ARRAY_PORT_ARBITER_FIXED_PRIO_EN: A always wins)
module array_port_arbiter #(
   parameter int datlen    = 12,
   parameter int size      = 64,
   parameter int size_log2 = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   array_port_arbiter_if.slave  a,
   array_port_arbiter_if.slave  b,
   output logic                 arr_put,
   output logic [size_log2-1:0] arr_put_index,
   output logic [datlen-1:0]    arr_put_val,
   output logic                 arr_get,
   output logic [size_log2-1:0] arr_get_index,
   input  logic [datlen-1:0]    arr_get_val,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, STROBE, SETTLE, ACK} state_t;

   localparam logic [size_log2:0] size_w = (size_log2 + 1)'(size);

   state_t               state_q, state_d;
   logic                 grant_b_q, grant_b_d;
   logic                 last_b_q, last_b_d;
   logic                 wr_q, wr_d;
   logic [size_log2-1:0] idx_q, idx_d;
   logic [datlen-1:0]    wdata_q, wdata_d;
   logic                 oor_q, oor_d;
   logic                 pick_b;
   logic                 put_q, put_d, get_q, get_d;
   logic                 a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic                 a_err_q, a_err_d, b_err_q, b_err_d;
   logic                 busy_q, busy_d;
   logic [datlen-1:0]    a_rdata_q, b_rdata_q;

   always_comb begin
      state_d   = state_q;
      grant_b_d = grant_b_q;
      last_b_d  = last_b_q;
      wr_d      = wr_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      oor_d     = oor_q;
      pick_b    = 1'b0;
      case (state_q)
         IDLE: begin
            if (a.req || b.req) begin
`ifdef ARRAY_PORT_ARBITER_FIXED_PRIO_EN
               pick_b = !a.req;
`else
               // last_b_q high means B was served last, so A has the turn
               pick_b = b.req && (!a.req || !last_b_q);
`endif
               grant_b_d = pick_b;
               last_b_d  = pick_b;
               wr_d      = pick_b ? b.wr    : a.wr;
               idx_d     = pick_b ? b.index : a.index;
               wdata_d   = pick_b ? b.wdata : a.wdata;
               oor_d     = {1'b0, idx_d} >= size_w;
               state_d   = oor_d ? ACK : STROBE;
            end
         end
         STROBE:  state_d = SETTLE;
         SETTLE:  state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // outputs are registered from next-state so they line up with the state they belong to
      put_d   = (state_d == STROBE) && wr_d;
      get_d   = (state_d == STROBE) && !wr_d;
      a_ack_d = (state_d == ACK) && !grant_b_d;
      b_ack_d = (state_d == ACK) && grant_b_d;
      a_err_d = a_ack_d && oor_d;
      b_err_d = b_ack_d && oor_d;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_b_q <= 1'b0;
         last_b_q  <= 1'b1;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         oor_q     <= 1'b0;
         put_q     <= 1'b0;
         get_q     <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         busy_q    <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_b_q <= grant_b_d;
         last_b_q  <= last_b_d;
         wr_q      <= wr_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         oor_q     <= oor_d;
         put_q     <= put_d;
         get_q     <= get_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         busy_q    <= busy_d;
         // the array presents read data by the end of SETTLE
         if (state_q == SETTLE && !wr_q) begin
            if (grant_b_q) b_rdata_q <= arr_get_val;
            else           a_rdata_q <= arr_get_val;
         end
      end
   end

   assign arr_put       = put_q;
   assign arr_get       = get_q;
   assign arr_put_index = idx_q;
   assign arr_get_index = idx_q;
   assign arr_put_val   = wdata_q;
   assign busy          = busy_q;
   assign a.ack         = a_ack_q;
   assign a.err         = a_err_q;
   assign a.rdata       = a_rdata_q;
   assign b.ack         = b_ack_q;
   assign b.err         = b_err_q;
   assign b.rdata       = b_rdata_q;
endmodule

// File: tb/tb_array_port_arbiter.sv
// tb/tb_array_port_arbiter.sv - directed self-checking bench for array_port_arbiter
module tb_array_port_arbiter;
   localparam int DL = 12;
   localparam int SZ = 40;
   localparam int SL = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          arr_put, arr_get, busy;
   logic [SL-1:0] arr_put_index, arr_get_index;
   logic [DL-1:0] arr_put_val;
   logic [DL-1:0] arr_get_val = '0;
   logic [DL-1:0] mem [0:63];

   int passed = 0;
   int total  = 0;
   int shape_bad = 0;
   bit prev_strobe = 1'b0;

   always #5 clk = ~clk;

   array_port_arbiter_if #(.datlen(DL), .size_log2(SL)) a_if ();
   array_port_arbiter_if #(.datlen(DL), .size_log2(SL)) b_if ();

   array_port_arbiter #(.datlen(DL), .size(SZ), .size_log2(SL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a_if.slave),
      .b            (b_if.slave),
      .arr_put      (arr_put),
      .arr_put_index(arr_put_index),
      .arr_put_val  (arr_put_val),
      .arr_get      (arr_get),
      .arr_get_index(arr_get_index),
      .arr_get_val  (arr_get_val),
      .busy         (busy)
   );

   // edge-strobed array model
   always @(posedge clk) begin
      if (arr_put) mem[arr_put_index] <= arr_put_val;
      if (arr_get) arr_get_val <= mem[arr_get_index];
   end

   always @(negedge clk) begin
      if (arr_put && arr_get) shape_bad++;
      if ((arr_put || arr_get) && prev_strobe) shape_bad++;
      prev_strobe = arr_put || arr_get;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic txn(input bit use_b, input bit wr, input logic [SL-1:0] idx, input logic [DL-1:0] wd,
                      output int strobe_at, output int ack_at, output int nstrobe,
                      output logic [SL-1:0] s_idx, output logic [DL-1:0] s_val,
                      output logic ack_err, output logic [DL-1:0] ack_rdata);
      strobe_at = -1; ack_at = -1; nstrobe = 0; s_idx = '0; s_val = '0; ack_err = 1'b0; ack_rdata = '0;
      if (use_b) begin
         b_if.wr = wr; b_if.index = idx; b_if.wdata = wd; b_if.req = 1'b1;
      end else begin
         a_if.wr = wr; a_if.index = idx; a_if.wdata = wd; a_if.req = 1'b1;
      end
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (arr_put || arr_get) begin
            nstrobe++;
            if (strobe_at < 0) begin
               strobe_at = c;
               s_idx = arr_put ? arr_put_index : arr_get_index;
               s_val = arr_put_val;
            end
         end
         if (use_b ? b_if.ack : a_if.ack) begin
            ack_at    = c;
            ack_err   = use_b ? b_if.err : a_if.err;
            ack_rdata = use_b ? b_if.rdata : a_if.rdata;
            break;
         end
      end
      a_if.req = 1'b0;
      b_if.req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int sa, aa, ns;
      logic [SL-1:0] si;
      logic [DL-1:0] sv, rd;
      logic er;
      int acks_a[$], acks_b[$], puts[$];
      int k;

      for (int i = 0; i < 64; i++) mem[i] = '0;
      a_if.req = 0; a_if.wr = 0; a_if.index = '0; a_if.wdata = '0;
      b_if.req = 0; b_if.wr = 0; b_if.index = '0; b_if.wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_put", arr_put, 0);
      check("rst_get", arr_get, 0);
      check("rst_a_ack", a_if.ack, 0);
      check("rst_b_ack", b_if.ack, 0);
      check("rst_a_err", a_if.err, 0);
      check("rst_a_rdata", a_if.rdata, 0);
      check("rst_b_rdata", b_if.rdata, 0);
      check("rst_put_index", arr_put_index, 0);
      check("rst_put_val", arr_put_val, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // contention straight after reset, both held for four slots
      a_if.wr = 1; a_if.index = 6'd10; a_if.wdata = 12'h111; a_if.req = 1;
      b_if.wr = 1; b_if.index = 6'd11; b_if.wdata = 12'h222; b_if.req = 1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (arr_put) puts.push_back(int'(arr_put_index));
         if (a_if.ack) acks_a.push_back(c);
         if (b_if.ack) acks_b.push_back(c);
      end
      a_if.req = 0; b_if.req = 0;
      repeat (2) @(negedge clk);
`ifdef ARRAY_PORT_ARBITER_FIXED_PRIO_EN
      check("fp_a_acks", acks_a.size(), 4);
      check("fp_b_acks", acks_b.size(), 0);
      check("fp_a_ack0", qget(acks_a, 0), 3);
      check("fp_a_ack3", qget(acks_a, 3), 15);
      check("fp_put1", qget(puts, 1), 10);
      check("fp_put3", qget(puts, 3), 10);
`else
      check("rr_a_acks", acks_a.size(), 2);
      check("rr_b_acks", acks_b.size(), 2);
      check("rr_a_ack0", qget(acks_a, 0), 3);
      check("rr_b_ack0", qget(acks_b, 0), 7);
      check("rr_a_ack1", qget(acks_a, 1), 11);
      check("rr_b_ack1", qget(acks_b, 1), 15);
      check("rr_put0", qget(puts, 0), 10);
      check("rr_put1", qget(puts, 1), 11);
      check("rr_put2", qget(puts, 2), 10);
      check("rr_put3", qget(puts, 3), 11);
`endif
      check("cont_idle", busy, 0);

      // single write then read-back
      txn(0, 1, 6'd5, 12'hABC, sa, aa, ns, si, sv, er, rd);
      check("wr_strobe_at", sa, 1);
      check("wr_nstrobe", ns, 1);
      check("wr_put_index", si, 5);
      check("wr_put_val", sv, 12'hABC);
      check("wr_ack_at", aa, 3);
      check("wr_err", er, 0);
      txn(0, 0, 6'd5, 12'h000, sa, aa, ns, si, sv, er, rd);
      check("rd_strobe_at", sa, 1);
      check("rd_nstrobe", ns, 1);
      check("rd_get_index", si, 5);
      check("rd_ack_at", aa, 3);
      check("rd_rdata", rd, 12'hABC);
      check("rd_err", er, 0);

      // requester B has its own rdata
      txn(1, 1, 6'd7, 12'h123, sa, aa, ns, si, sv, er, rd);
      check("b_wr_ack_at", aa, 3);
      txn(1, 0, 6'd7, 12'h000, sa, aa, ns, si, sv, er, rd);
      check("b_rd_rdata", rd, 12'h123);
      check("b_rd_a_rdata_kept", a_if.rdata, 12'hABC);

      // out-of-range and last-valid index
      txn(0, 0, 6'd45, 12'h000, sa, aa, ns, si, sv, er, rd);
      check("oor45_ack_at", aa, 1);
      check("oor45_nstrobe", ns, 0);
      check("oor45_err", er, 1);
      check("oor45_rdata_kept", rd, 12'hABC);
      txn(0, 0, 6'd40, 12'h000, sa, aa, ns, si, sv, er, rd);
      check("oor40_err", er, 1);
      check("oor40_nstrobe", ns, 0);
      txn(0, 1, 6'd39, 12'h5A5, sa, aa, ns, si, sv, er, rd);
      check("in39_wr_err", er, 0);
      check("in39_wr_nstrobe", ns, 1);
      txn(0, 0, 6'd39, 12'h000, sa, aa, ns, si, sv, er, rd);
      check("in39_rdata", rd, 12'h5A5);

      // back-to-back writes from A with req held
      acks_a.delete(); puts.delete();
      k = 0;
      a_if.wr = 1; a_if.index = 6'd0; a_if.wdata = 12'h100; a_if.req = 1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (arr_put) puts.push_back(c * 100 + int'(arr_put_index));
         if (a_if.ack) begin
            acks_a.push_back(c);
            k++;
            if (k < 3) begin
               a_if.index = 6'(k); a_if.wdata = 12'h100 + 12'(k);
            end else a_if.req = 0;
         end
      end
      check("b2b_acks", acks_a.size(), 3);
      check("b2b_ack0", qget(acks_a, 0), 3);
      check("b2b_ack1", qget(acks_a, 1), 7);
      check("b2b_ack2", qget(acks_a, 2), 11);
      check("b2b_put0", qget(puts, 0), 100);
      check("b2b_put1", qget(puts, 1), 501);
      check("b2b_put2", qget(puts, 2), 902);

      // reset while the put strobe is high
      a_if.wr = 1; a_if.index = 6'd3; a_if.wdata = 12'h333; a_if.req = 1;
      @(negedge clk);
      check("mid_put_high", arr_put, 1);
      check("mid_busy_high", busy, 1);
      rst_n = 1'b0; a_if.req = 0;
      @(negedge clk);
      check("mid_put_dropped", arr_put, 0);
      check("mid_busy_dropped", busy, 0);
      check("mid_no_ack", a_if.ack, 0);
      rst_n = 1'b1;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (a_if.ack || b_if.ack) k++;
      end
      check("mid_no_late_ack", k, 0);
      acks_a.delete(); acks_b.delete();
      a_if.wr = 1; a_if.index = 6'd20; a_if.wdata = 12'h444; a_if.req = 1;
      b_if.wr = 1; b_if.index = 6'd21; b_if.wdata = 12'h555; b_if.req = 1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (a_if.ack) begin acks_a.push_back(c); a_if.req = 0; end
         if (b_if.ack) begin acks_b.push_back(c); b_if.req = 0; end
      end
      check("post_rst_a_first", qget(acks_a, 0), 3);
      check("post_rst_b_next", qget(acks_b, 0), 7);
      txn(0, 0, 6'd3, 12'h000, sa, aa, ns, si, sv, er, rd);
      check("mid_write_kept", rd, 12'h333);

      check("strobe_shape", shape_bad, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
